// File: rtl/rsa_mont_pre.sv
// rsa_mont_pre: maps y into the Montgomery domain, t = y*2^256 mod N.
// Define RSA_MONT_PRE_CHK_EN to add the even-modulus check and err output.
module rsa_mont_pre (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] N,
  input  logic [255:0] y,
  output logic [255:0] t,
  output logic         finish,
`ifdef RSA_MONT_PRE_CHK_EN
  output logic         err,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    RUN
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [256:0] acc_q, acc_d;
  logic [255:0] n_q, n_d;
  logic [255:0] t_q, t_d;
  logic         fin_q, fin_d;

  logic [256:0] nx;
  logic [256:0] dbl;
  logic [256:0] red_acc;
  logic [256:0] run_acc;

  // acc < N_r holds in RUN, so the doubled value fits 257 bits
  assign nx      = {1'b0, n_q};
  assign dbl     = {acc_q[255:0], 1'b0};
  assign red_acc = (acc_q >= nx) ? acc_q - nx : acc_q;
  assign run_acc = (dbl >= nx) ? dbl - nx : dbl;

`ifdef RSA_MONT_PRE_CHK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    n_d     = n_q;
    t_d     = t_q;
    fin_d   = 1'b0;
`ifdef RSA_MONT_PRE_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = N;
          acc_d   = {1'b0, y};
          state_d = REDUCE;
`ifdef RSA_MONT_PRE_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      REDUCE: begin
        acc_d   = red_acc;
        cnt_d   = 8'd0;
        state_d = RUN;
`ifdef RSA_MONT_PRE_CHK_EN
        if (!n_q[0]) begin
          t_d     = '0;
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      RUN: begin
        acc_d = run_acc;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          t_d     = run_acc[255:0];
          fin_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      t_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      t_q     <= t_d;
      fin_q   <= fin_d;
    end
  end

`ifdef RSA_MONT_PRE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign t      = t_q;
  assign finish = fin_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/rsa_mont_pre.md
# rsa_mont_pre

Montgomery pre-processing unit for the RSA datapath. It converts an operand into the Montgomery domain by computing t = y·2^256 mod N. It is the entry-side counterpart to the Montgomery product block, which strips one 2^256 factor per multiply. It uses the same start/finish handshake and sits ahead of the product block in the RSA core.

## Interface
- No parameters; operand width is fixed at 256 bits.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- N  input  256  modulus; odd, nonzero.
- y  input  256  operand; must satisfy y < 2N.
- t  output  256  result y·2^256 mod N; valid from the finish cycle, held until the next accepted start.
- finish  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after start is accepted until the finish cycle, exclusive.
- err  output  1  only with RSA_MONT_PRE_CHK_EN; see Configuration.

## Operation
- States: IDLE, REDUCE, RUN, DONE-via-IDLE. There is no separate DONE state: finish is registered on the final RUN edge.
- IDLE: when start=1, latch N into N_r and y into acc (257-bit), then go to REDUCE. When start=0, hold state and hold t.
- REDUCE, one edge: if acc ≥ N_r then acc ← acc − N_r; clear cnt to 0; go to RUN.
- RUN, 256 edges with cnt = 0..255:
  - acc ← 2·acc, computed at 257 bits.
  - If the doubled value ≥ N_r, subtract N_r in the same cycle.
  - Invariant: acc < N_r after every step.
- On the edge with cnt=255:
  - t ← acc_next[255:0]
  - finish ← 1
  - state ← IDLE
- Arithmetic rules:
  - The intermediate is 257 bits because 2·acc < 2N ≤ 2^257.
  - The compare uses the full 257 bits.
  - The subtraction never underflows.
- start while busy: ignored. Inputs N and y may change freely after the accepting edge.
- start=1 in the finish cycle: the state is already IDLE, so the request is accepted. Back-to-back operation gives one result per 258 cycles.
- y ≥ 2N: the output is unspecified. Upstream must not issue it, and the bench does not drive it.

## Timing
- Reset values (asynchronous assertion):
  - state=IDLE, cnt=0, acc=0, N_r=0
  - t=0, finish=0, busy=0, err=0
- Reset mid-operation aborts immediately. No finish is emitted, and t returns to 0.
- Latency:
  - Edge E0 samples start.
  - Edge E1 performs REDUCE.
  - Edges E2..E257 perform RUN.
  - finish=1 and t are valid in the cycle following E257, i.e. 257 edges after E0.
- finish is exactly one cycle wide. It is cleared on the next edge regardless of start.
- busy is 1 in the cycles following E0..E256.

## Configuration
- RSA_MONT_PRE_CHK_EN defined:
  - Adds the err output and a modulus check in REDUCE.
  - If N_r[0]=0 (even or zero modulus): t ← 0, err ← 1 and finish ← 1 on edge E1, then return to IDLE. RUN is skipped.
  - err stays set until the next accepted start, which clears it.
  - Valid moduli give err=0 and the normal latency.
- RSA_MONT_PRE_CHK_EN undefined:
  - No err port and no check.
  - An even N runs the full 257 edges with an unspecified t.

## Test plan
- N=13, y=5, start pulse → finish exactly 257 edges later; t=2; busy high 257 cycles.
- N=3, y=1 → t=1. Immediately restart with y=0 in the finish cycle → second finish 257 edges later with t=0.
- N=2^256−189, y=N−1 → t=2^256−378, which exercises the full-width 257-bit compare and subtract.
- N=13, y=18 (exercises REDUCE) → t=2. Toggle start and y during busy → no effect on the result.
- Deassert rst_n at RUN cnt=100 → t=0, finish=0, busy=0 immediately. After release, a new start with N=13, y=5 → t=2.
- With RSA_MONT_PRE_CHK_EN: N=12, y=5 → finish and err=1 on E1, t=0. Next start with N=13, y=5 → err=0, t=2.
